// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V instruction-side front end:
// loader FSM state encoding and the architectural NOP.
package riscv_pkg;

    typedef enum logic [1:0] {
        LDR_HDR_LO = 2'd0,
        LDR_HDR_HI = 2'd1,
        LDR_LOAD   = 2'd2,
        LDR_RUN    = 2'd3
    } ldr_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: 2^ADDR_W x 32, one synchronous write port and one
// combinational read port so the single-cycle core sees zero fetch latency.
module instr_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed little-endian program image into instruction RAM
// while holding the core in reset, then serves instructions from the core's PC.
module instr_mem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        reload,
    input  logic [31:0] PC,
    output logic [31:0] instr,
    output logic        core_rst,
    output logic        ovf
);
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    ldr_state_e  state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic        ovf_q, ovf_d;
    logic        core_rst_q;

    logic        xfer;
    logic        ram_we;
    logic        word_in_range;
    logic [15:0] wcnt_inc;
    logic [31:0] ram_rdata;
    logic        unused_pc_bits;

    assign byte_ready    = (state_q != LDR_RUN);
    assign xfer          = byte_valid && byte_ready;
    assign wcnt_inc      = wcnt_q + 16'd1;
    assign word_in_range = ({16'd0, wcnt_q} < DEPTH);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        ovf_d   = ovf_q;
        ram_we  = 1'b0;
        case (state_q)
            LDR_HDR_LO: begin
                if (xfer) begin
                    n_d[7:0] = byte_i;
                    state_d  = LDR_HDR_HI;
                end
            end
            LDR_HDR_HI: begin
                if (xfer) begin
                    n_d[15:8] = byte_i;
                    wcnt_d    = 16'd0;
                    lane_d    = 2'd0;
                    state_d   = ({byte_i, n_q[7:0]} == 16'd0) ? LDR_RUN : LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = byte_i;
                        2'd1: asm_d[15:8]  = byte_i;
                        2'd2: asm_d[23:16] = byte_i;
                        default: begin
                            // Words past the RAM depth are consumed but dropped.
                            ram_we = word_in_range;
                            ovf_d  = ovf_q | ~word_in_range;
                            wcnt_d = wcnt_inc;
                            if (wcnt_inc == n_q) begin
                                state_d = LDR_RUN;
                            end
                        end
                    endcase
                end
            end
            LDR_RUN: begin
                if (reload) begin
                    state_d = LDR_HDR_LO;
                    n_d     = 16'd0;
                    wcnt_d  = 16'd0;
                    lane_d  = 2'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = LDR_HDR_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LDR_HDR_LO;
            n_q        <= 16'd0;
            wcnt_q     <= 16'd0;
            lane_q     <= 2'd0;
            asm_q      <= 24'd0;
            ovf_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            ovf_q      <= ovf_d;
            core_rst_q <= (state_d != LDR_RUN);
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wcnt_q[ADDR_W-1:0]),
        .wdata ({byte_i, asm_q}),
        .raddr (PC[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    // PC is a byte address that wraps at the RAM size.
    assign unused_pc_bits = ^{PC[31:ADDR_W+2], PC[1:0]};

    assign instr    = (state_q == LDR_RUN) ? ram_rdata : NOP_INSTR;
    assign core_rst = core_rst_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction-side front end for the single-cycle RISC_V core. Holds the core in reset while it receives a program image over a byte-wide valid/ready stream, writes it into on-chip instruction RAM, then releases the core and serves instructions combinationally from the core's PC. A `reload` pulse restarts the load sequence without a system reset.

## Interface
- `ADDR_W`, 8: word-address width; RAM depth = 2^ADDR_W 32-bit words.
- `NOP_INSTR`, 32'h0000_0013: value driven on `instr` while not in RUN (`addi x0,x0,0`).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_i`  in  8  program image byte.
- `byte_valid`  in  1  `byte_i` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `reload`  in  1  single-cycle request to reload; honoured only in RUN.
- `PC`  in  32  byte address from the core.
- `instr`  out  32  instruction to the core.
- `core_rst`  out  1  reset to the core; high until the image is loaded.
- `ovf`  out  1  sticky: image word count exceeded RAM depth.

## Operation
- Image format: 2-byte header N (word count, little-endian, low byte first), then 4·N bytes, each word little-endian (byte 0 = instr[7:0]).
- Handshake: byte transferred on a rising edge with `byte_valid && byte_ready`. `byte_ready` = 1 in HDR_LO, HDR_HI and LOAD; 0 in RUN. `byte_valid` without `byte_ready` is ignored, no buffering.
- FSM states: HDR_LO, HDR_HI, LOAD, RUN.
  - HDR_LO: on transfer, capture N[7:0] -> HDR_HI.
  - HDR_HI: on transfer, capture N[15:8]; if full N == 0 -> RUN, else -> LOAD with word counter = 0 and lane = 0.
  - LOAD: on transfer, place byte in lane (2-bit counter) of assembly register; on lane 3 write assembled word to RAM[word counter[ADDR_W-1:0]], increment word counter; when the incremented counter equals N -> RUN.
  - RUN: on `reload` -> HDR_LO, clearing counters and `ovf`; RAM contents retained until overwritten.
- Overflow: words with index >= 2^ADDR_W are consumed but not written; `ovf` set on the first such word, held until reset or reload.
- `instr` = RAM[PC[ADDR_W+1:2]] in RUN, else NOP_INSTR. PC[1:0] and bits above ADDR_W+1 ignored (address wraps).
- `core_rst` = 1 in every state except RUN, registered from the state.
- Reset mid-load: state -> HDR_LO, counters/lane/`ovf` -> 0, `core_rst` -> 1; RAM not cleared; partial word discarded.

## Timing
- Reset values: `byte_ready`=1, `core_rst`=1, `ovf`=0, `instr`=NOP_INSTR; state HDR_LO.
- RAM write synchronous on the edge accepting lane-3 byte; read combinational (zero latency, matches single-cycle core).
- `core_rst` falls on the edge that accepts the final byte (or HDR_HI byte when N=0); first instruction fetched in the following cycle at PC=0.
- `reload` in RUN: `core_rst` rises and `byte_ready` rises on the next edge; a byte presented with `reload` is not accepted.
- Maximum throughput: one byte per cycle; image of N words takes 2 + 4N accepted transfers.

## Structure
- Shared package `riscv_pkg`: FSM state enum (`LDR_HDR_LO`, `LDR_HDR_HI`, `LDR_LOAD`, `LDR_RUN`) and `NOP_INSTR` constant.
- One sub-module: `instr_ram` (2^ADDR_W × 32, one synchronous write port, one combinational read port). FSM, counters and assembly register stay in `instr_mem_loader`.

## Test plan
- Basic load: stream 02 00, 13 05 10 00, 93 05 20 00 back-to-back -> `core_rst` falls after 10th byte; PC=0 gives 32'h0010_0513, PC=4 gives 32'h0020_0593.
- Gapped valid: same image with `byte_valid` toggling every other cycle -> identical RAM contents, `core_rst` falls only after 10th accepted byte; `instr` = NOP_INSTR throughout load.
- Empty image: 00 00 -> RUN two transfers after reset, `core_rst`=0, `ovf`=0.
- Overflow with ADDR_W=2: N=5, words W0..W4 -> `ovf`=1, RAM[0..3]=W0..W3, W4 dropped, RUN reached after 22 transfers; PC=16 reads W0.
- Reset mid-load: assert `rst` after 5 bytes -> `core_rst`=1, state HDR_LO; fresh 1-word image loads correctly, PC=0 returns new word.
- Reload: in RUN pulse `reload` with `byte_valid`=1 -> byte not taken, `core_rst`=1 next cycle; new 1-word image overwrites RAM[0], other words retained.
